// File: rtl/t_out_arb_if.sv
// t_out_arb_if: request/backpressure in, select/valid/grants out,
// for one output port of the tree switch.
interface t_out_arb_if #(
  parameter int VC_W = 2
) ();
  localparam int SEL_W = $clog2(VC_W*2);

  logic [VC_W-1:0]  a_req;
  logic [VC_W-1:0]  b_req;
  logic [VC_W-1:0]  out_bp;
  logic [SEL_W-1:0] sel;
  logic [VC_W-1:0]  out_v;
  logic [VC_W-1:0]  a_gnt;
  logic [VC_W-1:0]  b_gnt;

  modport master (
    output a_req,
    output b_req,
    output out_bp,
    input  sel,
    input  out_v,
    input  a_gnt,
    input  b_gnt
  );

  modport slave (
    input  a_req,
    input  b_req,
    input  out_bp,
    output sel,
    output out_v,
    output a_gnt,
    output b_gnt
  );
endinterface

// File: rtl/t_out_arb.sv
// t_out_arb: per-output-port arbiter for the tree switch.
// Picks one VC, then one direction, and grants it in the same cycle.
module t_out_arb #(
  parameter int VC_W        = 2,
  parameter bit FAIR_VC_ARB = 1'b0
) (
  input  logic       clk,
  input  logic       rst,
  t_out_arb_if.slave io
);
  localparam int SEL_W = $clog2(VC_W*2);
  localparam int PTR_W = (VC_W > 1) ? $clog2(VC_W) : 1;

  logic [VC_W-1:0]  elig;
  logic [VC_W-1:0]  dir_ptr_q;
  logic [VC_W-1:0]  dir_ptr_d;
  logic [PTR_W-1:0] vc_ptr_q;
  logic [PTR_W-1:0] win_vc;
  logic [PTR_W-1:0] idx;
  logic             found;
  logic             win_dir;
  logic             gnt;

  assign elig = (io.a_req | io.b_req) & ~io.out_bp;

  // Static priority is the rotating search with the pointer held at 0.
  always_comb begin
    found  = 1'b0;
    win_vc = '0;
    idx    = '0;
    for (int i = 0; i < VC_W; i++) begin
      idx = vc_ptr_q + PTR_W'(i);
      if (!found && elig[idx]) begin
        found  = 1'b1;
        win_vc = idx;
      end
    end
  end

  always_comb begin
    win_dir = io.a_req[win_vc] &
              (~io.b_req[win_vc] | dir_ptr_q[win_vc]);
  end

  assign gnt = found & ~rst;

  always_comb begin
    io.out_v  = '0;
    io.a_gnt  = '0;
    io.b_gnt  = '0;
    io.sel    = '0;
    dir_ptr_d = dir_ptr_q;
    if (gnt) begin
      io.out_v[win_vc] = 1'b1;
      if (win_dir) io.a_gnt[win_vc] = 1'b1;
      else         io.b_gnt[win_vc] = 1'b1;
      io.sel = SEL_W'(int'(win_dir) * VC_W + int'(win_vc));
      dir_ptr_d[win_vc] = ~win_dir;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) dir_ptr_q <= '1;
    else     dir_ptr_q <= dir_ptr_d;
  end

  if (FAIR_VC_ARB && VC_W > 1) begin : g_vc_ptr
    logic [PTR_W-1:0] vc_ptr_d;

    always_comb begin
      vc_ptr_d = vc_ptr_q;
      if (gnt) vc_ptr_d = win_vc + PTR_W'(1);
    end

    always_ff @(posedge clk) begin
      if (rst) vc_ptr_q <= '0;
      else     vc_ptr_q <= vc_ptr_d;
    end
  end else begin : g_no_vc_ptr
    assign vc_ptr_q = '0;
  end
endmodule

// File: tb/tb_t_out_arb.sv
// tb_t_out_arb: directed vector table plus a random run with a
// reference model feeding a scoreboard queue, on three configurations.
module tb_t_out_arb;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  t_out_arb_if #(.VC_W(2)) i0 ();
  t_out_arb_if #(.VC_W(2)) i1 ();
  t_out_arb_if #(.VC_W(4)) i2 ();

  t_out_arb #(.VC_W(2), .FAIR_VC_ARB(1'b0)) u0 (
    .clk(clk), .rst(rst), .io(i0.slave));
  t_out_arb #(.VC_W(2), .FAIR_VC_ARB(1'b1)) u1 (
    .clk(clk), .rst(rst), .io(i1.slave));
  t_out_arb #(.VC_W(4), .FAIR_VC_ARB(1'b1)) u2 (
    .clk(clk), .rst(rst), .io(i2.slave));

  typedef struct {
    int         dut;
    bit         r;
    logic [3:0] a, b, bp;
    int         sel;
    logic [3:0] ov, ag, bg;
  } vec_t;

  typedef struct {
    bit         found;
    int         vc;
    bit         dir;
    int         sel;
    logic [3:0] ov, ag, bg;
  } exp_t;

  typedef struct {
    int   dut;
    exp_t e;
  } sb_t;

  int   checks = 0;
  int   failures = 0;
  vec_t tbl[$];
  sb_t  sbq[$];

  int         vw[3] = '{2, 2, 4};
  bit         fr[3] = '{1'b0, 1'b1, 1'b1};
  int         mptr[3];
  logic [3:0] mdp[3];
  logic [3:0] fa[3], fb[3], dbp[3];
  int         wa[3][4], wb[3][4];
  int         mx[3];

  function automatic vec_t mk(int d, bit r, logic [3:0] a, b, bp,
                              int s, logic [3:0] ov, ag, bg);
    vec_t t;
    t.dut = d; t.r = r; t.a = a; t.b = b; t.bp = bp;
    t.sel = s; t.ov = ov; t.ag = ag; t.bg = bg;
    return t;
  endfunction

  function automatic exp_t model(int n, bit fair, logic [3:0] a, b, bp,
                                 int ptr, logic [3:0] dp);
    exp_t e;
    int   v;
    e.found = 0; e.vc = 0; e.dir = 0; e.sel = 0;
    e.ov = '0; e.ag = '0; e.bg = '0;
    for (int k = 0; k < n; k++) begin
      v = fair ? (ptr + k) % n : k;
      if ((a[v] || b[v]) && !bp[v]) begin
        e.found = 1;
        e.vc = v;
        e.dir = (a[v] && b[v]) ? dp[v] : a[v];
        e.ov[v] = 1'b1;
        if (e.dir) e.ag[v] = 1'b1;
        else       e.bg[v] = 1'b1;
        e.sel = (e.dir ? n : 0) + v;
        return e;
      end
    end
    return e;
  endfunction

  task automatic drive(input int d, input logic [3:0] a, b, bp);
    case (d)
      0: begin i0.a_req = a[1:0]; i0.b_req = b[1:0]; i0.out_bp = bp[1:0]; end
      1: begin i1.a_req = a[1:0]; i1.b_req = b[1:0]; i1.out_bp = bp[1:0]; end
      default: begin i2.a_req = a; i2.b_req = b; i2.out_bp = bp; end
    endcase
  endtask

  task automatic sample(input int d, output int s,
                        output logic [3:0] ov, ag, bg);
    ov = '0; ag = '0; bg = '0;
    case (d)
      0: begin
        s = int'(i0.sel);
        ov[1:0] = i0.out_v; ag[1:0] = i0.a_gnt; bg[1:0] = i0.b_gnt;
      end
      1: begin
        s = int'(i1.sel);
        ov[1:0] = i1.out_v; ag[1:0] = i1.a_gnt; bg[1:0] = i1.b_gnt;
      end
      default: begin
        s = int'(i2.sel);
        ov = i2.out_v; ag = i2.a_gnt; bg = i2.b_gnt;
      end
    endcase
  endtask

  initial begin
    int         s;
    logic [3:0] ov, ag, bg, msk;
    int         bound;
    sb_t        it;
    exp_t       e;

    for (int d = 0; d < 3; d++) drive(d, 4'h0, 4'h0, 4'h0);

    // Same-VC direction alternation, reset forces zero outputs
    tbl.push_back(mk(0, 1, 4'h1, 4'h1, 4'h0, 0, 4'h0, 4'h0, 4'h0));
    tbl.push_back(mk(0, 0, 4'h1, 4'h1, 4'h0, 2, 4'h1, 4'h1, 4'h0));
    tbl.push_back(mk(0, 0, 4'h1, 4'h1, 4'h0, 0, 4'h1, 4'h0, 4'h1));
    tbl.push_back(mk(0, 0, 4'h1, 4'h1, 4'h0, 2, 4'h1, 4'h1, 4'h0));
    tbl.push_back(mk(0, 0, 4'h1, 4'h1, 4'h0, 0, 4'h1, 4'h0, 4'h1));
    // Backpressured sole requester, then released
    tbl.push_back(mk(0, 0, 4'h0, 4'h2, 4'h2, 0, 4'h0, 4'h0, 4'h0));
    tbl.push_back(mk(0, 0, 4'h0, 4'h2, 4'h0, 1, 4'h2, 4'h0, 4'h2));
    tbl.push_back(mk(0, 0, 4'h1, 4'h0, 4'h1, 0, 4'h0, 4'h0, 4'h0));
    // Static VC priority
    tbl.push_back(mk(0, 0, 4'h3, 4'h0, 4'h0, 2, 4'h1, 4'h1, 4'h0));
    tbl.push_back(mk(0, 0, 4'h3, 4'h0, 4'h0, 2, 4'h1, 4'h1, 4'h0));
    tbl.push_back(mk(0, 0, 4'h3, 4'h0, 4'h0, 2, 4'h1, 4'h1, 4'h0));
    tbl.push_back(mk(0, 0, 4'h3, 4'h0, 4'h1, 3, 4'h2, 4'h2, 4'h0));
    // Round-robin over two VCs
    tbl.push_back(mk(1, 1, 4'h3, 4'h0, 4'h0, 0, 4'h0, 4'h0, 4'h0));
    tbl.push_back(mk(1, 0, 4'h3, 4'h0, 4'h0, 2, 4'h1, 4'h1, 4'h0));
    tbl.push_back(mk(1, 0, 4'h3, 4'h0, 4'h0, 3, 4'h2, 4'h2, 4'h0));
    tbl.push_back(mk(1, 0, 4'h3, 4'h0, 4'h0, 2, 4'h1, 4'h1, 4'h0));
    // Four VCs: pointer moved to 3, then wrap
    tbl.push_back(mk(2, 0, 4'h4, 4'h0, 4'h0, 6, 4'h4, 4'h4, 4'h0));
    tbl.push_back(mk(2, 0, 4'h9, 4'h0, 4'h0, 7, 4'h8, 4'h8, 4'h0));
    tbl.push_back(mk(2, 0, 4'h9, 4'h0, 4'h0, 4, 4'h1, 4'h1, 4'h0));
    tbl.push_back(mk(2, 0, 4'h9, 4'h0, 4'h0, 7, 4'h8, 4'h8, 4'h0));
    // Mid-stream reset restores A priority
    tbl.push_back(mk(0, 0, 4'h1, 4'h1, 4'h0, 2, 4'h1, 4'h1, 4'h0));
    tbl.push_back(mk(0, 1, 4'h1, 4'h1, 4'h0, 0, 4'h0, 4'h0, 4'h0));
    tbl.push_back(mk(0, 0, 4'h1, 4'h1, 4'h0, 2, 4'h1, 4'h1, 4'h0));
    tbl.push_back(mk(0, 0, 4'h1, 4'h1, 4'h0, 0, 4'h1, 4'h0, 4'h1));

    foreach (tbl[k]) begin
      @(negedge clk);
      rst = tbl[k].r;
      for (int d = 0; d < 3; d++) drive(d, 4'h0, 4'h0, 4'h0);
      drive(tbl[k].dut, tbl[k].a, tbl[k].b, tbl[k].bp);
      #2;
      sample(tbl[k].dut, s, ov, ag, bg);
      checks++;
      if (s != tbl[k].sel || ov !== tbl[k].ov ||
          ag !== tbl[k].ag || bg !== tbl[k].bg) begin
        failures++;
        $display("FAIL vec%0d dut%0d: got sel=%0d out_v=%b a_gnt=%b b_gnt=%b want sel=%0d out_v=%b a_gnt=%b b_gnt=%b",
                 k, tbl[k].dut, s, ov, ag, bg,
                 tbl[k].sel, tbl[k].ov, tbl[k].ag, tbl[k].bg);
      end
    end

    @(negedge clk);
    rst = 1'b1;
    for (int d = 0; d < 3; d++) drive(d, 4'h0, 4'h0, 4'h0);
    @(negedge clk);
    rst = 1'b0;
    for (int d = 0; d < 3; d++) begin
      mptr[d] = 0; mdp[d] = 4'hf; fa[d] = 4'h0; fb[d] = 4'h0;
      mx[d] = 0;
      for (int v = 0; v < 4; v++) begin wa[d][v] = 0; wb[d][v] = 0; end
    end

    for (int cyc = 0; cyc < 10000; cyc++) begin
      @(negedge clk);
      for (int d = 0; d < 3; d++) begin
        for (int v = 0; v < vw[d]; v++) begin
          if (!fa[d][v] && $urandom_range(0, 2) == 0) fa[d][v] = 1'b1;
          if (!fb[d][v] && $urandom_range(0, 2) == 0) fb[d][v] = 1'b1;
          dbp[d][v] = ($urandom_range(0, 3) == 0);
        end
        for (int v = vw[d]; v < 4; v++) dbp[d][v] = 1'b0;
        drive(d, fa[d], fb[d], dbp[d]);
        it.dut = d;
        it.e = model(vw[d], fr[d], fa[d], fb[d], dbp[d], mptr[d], mdp[d]);
        sbq.push_back(it);
      end
      #2;
      while (sbq.size() > 0) begin
        it = sbq.pop_front();
        e = it.e;
        sample(it.dut, s, ov, ag, bg);
        checks++;
        if (s != e.sel || ov !== e.ov || ag !== e.ag || bg !== e.bg) begin
          failures++;
          $display("FAIL rand cyc%0d dut%0d: got sel=%0d out_v=%b a_gnt=%b b_gnt=%b want sel=%0d out_v=%b a_gnt=%b b_gnt=%b",
                   cyc, it.dut, s, ov, ag, bg, e.sel, e.ov, e.ag, e.bg);
        end
        checks++;
        if ($countones(ov) > 1 || $countones(ag | bg) > 1 ||
            (ag & ~fa[it.dut]) != 0 || (bg & ~fb[it.dut]) != 0 ||
            ((ag | bg) & ~(ov & ~dbp[it.dut])) != 0) begin
          failures++;
          $display("FAIL invariant cyc%0d dut%0d: out_v=%b a_gnt=%b b_gnt=%b req_a=%b req_b=%b bp=%b",
                   cyc, it.dut, ov, ag, bg, fa[it.dut], fb[it.dut],
                   dbp[it.dut]);
        end
        if (e.found) begin
          mdp[it.dut][e.vc] = ~e.dir;
          if (fr[it.dut]) mptr[it.dut] = (e.vc + 1) % vw[it.dut];
        end
        for (int v = 0; v < vw[it.dut]; v++) begin
          if (fa[it.dut][v]) begin
            if (dbp[it.dut][v] || ag[v]) wa[it.dut][v] = 0;
            else if (fr[it.dut] ? (ov != 0) : ov[v]) wa[it.dut][v]++;
            if (wa[it.dut][v] > mx[it.dut]) mx[it.dut] = wa[it.dut][v];
          end
          if (fb[it.dut][v]) begin
            if (dbp[it.dut][v] || bg[v]) wb[it.dut][v] = 0;
            else if (fr[it.dut] ? (ov != 0) : ov[v]) wb[it.dut][v]++;
            if (wb[it.dut][v] > mx[it.dut]) mx[it.dut] = wb[it.dut][v];
          end
        end
        msk = ag;
        fa[it.dut] = fa[it.dut] & ~msk;
        msk = bg;
        fb[it.dut] = fb[it.dut] & ~msk;
      end
    end

    for (int d = 0; d < 3; d++) begin
      bound = fr[d] ? 2 * vw[d] : 2;
      checks++;
      if (mx[d] > bound) begin
        failures++;
        $display("FAIL starvation dut%0d: max wait=%0d limit=%0d",
                 d, mx[d], bound);
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/t_out_arb.md
Name: t_out_arb

Overview:
- Per-output-port arbiter for the tree-switch datapath.
- Shares one output direction (left, right or up0) between its two candidate input directions, A and B, across all VCs.
- Each cycle, produces the output mux select, the per-VC output valid and the per-input-VC grants, which the switch inverts to form input backpressure.
- Keeps fairness state so that neither direction, and optionally no VC, starves under sustained load.

Parameters:
- VC_W, DEFAULT_VC_W: number of virtual channels. Must be a power of 2 and ≥1.
- FAIR_VC_ARB, 0: 0 = static VC priority (lowest VC index wins); 1 = round-robin across VCs.
- SEL_W, $clog2(VC_W*2): width of the mux select. Derived; do not override.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- a_req  in  VC_W  direction A (upper mux operand) VC v holds a valid flit routed to this output
- b_req  in  VC_W  direction B (lower mux operand) VC v holds a valid flit routed to this output
- out_bp  in  VC_W  downstream backpressure per VC on this output
- sel  out  SEL_W  mux select; sel = dir*VC_W + vc, where dir=1 is A and dir=0 is B
- out_v  out  VC_W  output valid, one-hot or zero
- a_gnt  out  VC_W  grant to A VC v (flit consumed this cycle)
- b_gnt  out  VC_W  grant to B VC v (flit consumed this cycle)

Behaviour:
- One clock domain (clk). Reset is synchronous and active-high (rst).
- Grant path is combinational from req, out_bp and registered state. Transfer happens in the same cycle (0-cycle latency). State updates on the next clk edge.
- VC eligibility: VC v is eligible iff (a_req[v] | b_req[v]) & ~out_bp[v].
- VC choice:
  - FAIR_VC_ARB=0: lowest-index eligible VC wins.
  - FAIR_VC_ARB=1: first eligible VC searching upward from vc_ptr, wrapping from VC_W-1 to 0.
- Direction choice within the chosen VC v:
  - Only one of A/B requests: that one wins.
  - Both request: dir_ptr[v] wins (1 = A, 0 = B).
- Outputs when a winner (dir d, VC v) exists:
  - out_v = one-hot(v).
  - Exactly one of a_gnt[v] / b_gnt[v] = 1.
  - sel = d*VC_W + v.
- No eligible VC: out_v=0, a_gnt=0, b_gnt=0, sel=0.
- A requester whose VC is backpressured is never granted, even if it is the only requester.
- State update, on a grant only:
  - dir_ptr[v] <= ~d. The loser, or the other direction when uncontested, has priority next time on that VC.
  - FAIR_VC_ARB=1: vc_ptr <= (v+1) mod VC_W. Natural wrap, since VC_W is a power of 2.
  - Registers do not change on cycles without a grant.
- Reset values: vc_ptr=0; dir_ptr = all 1 (A favoured first).
  - While rst=1, all outputs are forced to 0 regardless of requests.
  - Reset mid-traffic drops the in-flight grant for that cycle. The requester keeps its flit and re-arbitrates after reset.
- Invariants:
  - popcount(out_v) ≤ 1.
  - popcount(a_gnt|b_gnt) ≤ 1.
  - a_gnt[v]|b_gnt[v] implies out_v[v] & ~out_bp[v].
  - a_gnt ⊆ a_req and b_gnt ⊆ b_req.
- VC_W=1: vc_ptr is unused and must not be synthesised; sel width is 1.

Test Plan (VC_W=2 unless noted):
1. Reset, then a_req=01, b_req=01, out_bp=00 held 4 cycles → a_gnt[0], b_gnt[0], a_gnt[0], b_gnt[0]; sel=2,0,2,0.
2. a_req=00, b_req=10, out_bp=10 → no grant, out_v=00. Deassert out_bp[1] → b_gnt=10, sel=1, out_v=10 in the same cycle.
3. FAIR_VC_ARB=0, a_req=11, b_req=00 for 3 cycles → VC0 granted every cycle, sel=2. FAIR_VC_ARB=1 with the same stimulus → grants alternate VC0, VC1, VC0 (sel=2,3,2).
4. VC_W=4, FAIR_VC_ARB=1, vc_ptr driven to 3 by a prior grant on VC2, a_req=1001 → VC3 granted, then VC0 (wrap), then VC3.
5. Mid-stream rst with a_req=01, b_req=01: all outputs 0 that cycle; after release, A is granted first (dir_ptr reset to 1).
6. Random req/out_bp for 10k cycles with a scoreboard: invariants hold; no requester with a continuously unblocked VC waits more than 2*VC_W grant cycles (FAIR=1) or more than 2 grants on its VC (FAIR=0, direction fairness).
